// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encoding and init-pattern codes for the register file
package regfile_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int INIT_PAT_ZERO  = 0;
  localparam int INIT_PAT_INDEX = 1;

endpackage

// File: rtl/regfile_init_fsm.sv
// rtl/regfile_init_fsm.sv - init sweep FSM: walks every register once, one per cycle
module regfile_init_fsm #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ZERO_REG     = 1,
  parameter int INIT_PATTERN = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  sweep_we,
  output logic [AW-1:0]         sweep_addr,
  output logic [DATA_WIDTH-1:0] sweep_data
);
  import regfile_pkg::*;

  localparam logic [0:0] ST_INIT  = INIT;
  localparam logic [0:0] ST_READY = READY;

  logic [0:0]    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == AW'(NUM_REGS - 1)) begin
            state <= ST_READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign init_busy  = (state == ST_INIT);
  assign sweep_we   = init_busy;
  assign sweep_addr = cnt;

  // Widen before the +1 so the last register gets NUM_REGS rather than wrapping to 0.
  always_comb begin
    sweep_data = '0;
    if (INIT_PATTERN == INIT_PAT_INDEX)
      sweep_data = DATA_WIDTH'(cnt) + DATA_WIDTH'(1);
    if (ZERO_REG != 0 && cnt == '0)
      sweep_data = '0;
  end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read-port register file with byte-enable writes; optional REGFILE_BYPASS_EN write-to-read forwarding
module regfile_multiport #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int ZERO_REG     = 1,
  parameter int INIT_PATTERN = 1,
  localparam int AW          = $clog2(NUM_REGS),
  localparam int BW          = DATA_WIDTH / 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     init_req,
  input  logic                                     wr_en,
  input  logic [AW-1:0]                            wr_addr,
  input  logic [DATA_WIDTH-1:0]                    wr_data,
  input  logic [BW-1:0]                            wr_be,
  output logic                                     wr_ready,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]          rd_addr,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic                                     init_busy
);
  import regfile_pkg::*;

  logic                  sweep_we;
  logic [AW-1:0]         sweep_addr;
  logic [DATA_WIDTH-1:0] sweep_data;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] merged_wr;

  regfile_init_fsm #(
    .NUM_REGS     (NUM_REGS),
    .DATA_WIDTH   (DATA_WIDTH),
    .ZERO_REG     (ZERO_REG),
    .INIT_PATTERN (INIT_PATTERN)
  ) u_init_fsm (
    .clk        (clk),
    .rst        (rst),
    .init_req   (init_req),
    .init_busy  (init_busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .sweep_data (sweep_data)
  );

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [BW-1:0]         be
  );
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < BW; b++)
      m[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    return m;
  endfunction

  assign wr_ready  = !init_busy;
  assign wr_fire   = wr_en && wr_ready && !(ZERO_REG != 0 && wr_addr == '0);
  assign merged_wr = byte_merge(mem[wr_addr], wr_data, wr_be);

  // Storage has no reset; the sweep is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (sweep_we)
      mem[sweep_addr] <= sweep_data;
    else if (wr_fire)
      mem[wr_addr] <= merged_wr;
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (!init_busy && !(ZERO_REG != 0 && rd_addr[p] == '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && rd_addr[p] == wr_addr)
          rd_data[p] = merged_wr;
        else
          rd_data[p] = mem[rd_addr[p]];
`else
        rd_data[p] = mem[rd_addr[p]];
`endif
      end
    end
  end

endmodule
